id_stage_pipe: RTL and testbench
================================

Name: id_stage_pipe

Overview:
Parametrised instruction-decode stage with its own ID/EXE pipeline register. It sits between IF and EXE in the 5-stage MIPS pipeline. The block contains:
- a register file, with a write-through bypass from WB
- a sign extender
- a load-use hazard detector that stalls IF and inserts a bubble
- a flush path for taken branches

Decode of the opcode stays in the existing combinational controller. Its outputs arrive on the ctrl_* inputs.

Parameters:
DATA_W, 32, register and operand width; must be at least 16.
REG_AW, 5, register index width; the file holds 2**REG_AW registers.
WB_BYPASS, 1, when 1, a same-cycle WB write is forwarded to the ID read ports.

Ports:
clk  input  1  clock
rst  input  1  reset
instr_valid  input  1  IF presents a valid instruction
instr  input  32  instruction word; src1=[25:21], src2=[20:16], rd=[15:11], imm=[15:0]
ctrl_is_imm  input  1  controller: Val2 is the immediate, dest is src2 field
ctrl_exe_cmd  input  4  controller EXE command
ctrl_br_type  input  2  controller branch type
ctrl_mem_r_en  input  1  controller load
ctrl_mem_w_en  input  1  controller store
ctrl_wb_en  input  1  controller writeback
wb_we  input  1  WB write enable
wb_dest  input  REG_AW  WB destination
wb_data  input  DATA_W  WB data
flush  input  1  branch taken in EXE; kill the instruction in ID
stall  output  1  hold PC and IF/ID (combinational)
ex_valid  output  1  ID/EXE holds a real instruction
ex_dest  output  REG_AW  destination register
ex_src1  output  REG_AW  source 1 index (for EXE forwarding)
ex_src2  output  REG_AW  source 2 index
ex_val1  output  DATA_W  operand 1
ex_val2  output  DATA_W  operand 2 (immediate or register)
ex_reg2  output  DATA_W  register src2 value (store data)
ex_exe_cmd  output  4  registered ctrl_exe_cmd
ex_br_type  output  2  registered ctrl_br_type
ex_mem_r_en  output  1  registered load
ex_mem_w_en  output  1  registered store
ex_wb_en  output  1  registered writeback

Interface decision: one clock, clk; reset rst is asynchronous and active-high.

Behaviour:
- Reset (async, on rst rising, held while high):
  - all 2**REG_AW registers = 0
  - every ex_* output = 0; stall = 0
- Register file:
  - write at posedge clk when wb_we && wb_dest != 0
  - register 0 always reads 0; writes to it are ignored
  - reads are combinational
  - with WB_BYPASS=1 and wb_we && wb_dest==srcN && srcN!=0, read N returns wb_data in the same cycle
  - with WB_BYPASS=0, the read returns the old value
- Immediate: imm sign-extended to DATA_W.
- Operand and dest selection:
  - val2 = ctrl_is_imm ? imm_ext : reg2
  - dest = ctrl_is_imm ? instr[20:16] : instr[15:11]
- Source use:
  - uses_src2 = !ctrl_is_imm || ctrl_mem_w_en
  - src1 is always used
- Load-use hazard: hazard = instr_valid && ex_valid && ex_mem_r_en && ex_dest!=0 && (ex_dest==src1 || (uses_src2 && ex_dest==src2)).
- stall = hazard && !flush (combinational).
- ID/EXE register, updated at posedge clk, priority order:
  1. flush → bubble
  2. hazard → bubble
  3. otherwise load the current decode; ex_valid = instr_valid
- Bubble: ex_valid, ex_mem_r_en, ex_mem_w_en, ex_wb_en all 0, ex_br_type = 0. Data fields are don't-care; the implementation drives 0.
- If instr_valid=0, the ID/EXE register loads with all enables forced to 0.
- Latency: decode to ex_* is exactly 1 cycle. A load-use pair costs exactly 1 bubble.
  - On the cycle after the bubble, ex_valid=0, so hazard clears. The load is then in MEM, and its result reaches the consumer via the EXE forwarding unit.
- Simultaneous WB write and ID read of the same register: covered by the bypass rule above.
- Reset mid-stall: outputs go to 0 immediately; stall drops because ex_valid=0.

Decomposition:
- Package id_pkg holds:
  - EXE_CMD and BR_TYPE localparams (NO_BR=2'd0 etc.)
  - field-slice constants (SRC1_HI/LO, SRC2_HI/LO, RD_HI/LO, IMM_W=16)
  - an id_ex struct-equivalent bit layout, if the team's flow permits
- Sub-module regfile_bypass holds the register file plus the WB bypass.
- Hazard logic, sign extend and the pipeline register stay in the top module.

Test Plan:
- Reset: assert rst mid-operation → all ex_* = 0, stall = 0; reading r5 → 0.
- WB bypass: write r3 = 32'hDEADBEEF with instr src1=3 in the same cycle.
  - WB_BYPASS=1 → next-cycle ex_val1 = DEADBEEF.
  - WB_BYPASS=0 → ex_val1 = 0.
- Register 0: wb_we=1, wb_dest=0, data=32'h1234; then read r0 → ex_val1 = 0.
- Immediate path: ctrl_is_imm=1, imm=16'hFFFE → ex_val2 = 32'hFFFFFFFE and ex_dest = instr[20:16].
- Load-use: a load to r4 is in ID/EXE; the next instr reads src2=4 with ctrl_is_imm=0.
  - stall=1 for exactly 1 cycle; the bubble has ex_valid=0.
  - Then the consumer enters with ex_valid=1.
  - Same case with ctrl_is_imm=1 and no store → no stall.
- Flush vs hazard: a load-use hazard and flush=1 in the same cycle → stall=0; next cycle ex_valid=0 and ex_wb_en=0.

Source files
------------

// File: rtl/id_pkg.sv
// Shared constants and control-bundle layout for the decode stage.
// Instruction field positions, EXE/branch encodings, ID/EXE control bits.
package id_pkg;

  localparam int SRC1_HI = 25;
  localparam int SRC1_LO = 21;
  localparam int SRC2_HI = 20;
  localparam int SRC2_LO = 16;
  localparam int RD_HI   = 15;
  localparam int RD_LO   = 11;
  localparam int IMM_W   = 16;

  localparam logic [3:0] EXE_NOP = 4'd0;
  localparam logic [3:0] EXE_MOV = 4'd1;
  localparam logic [3:0] EXE_ADD = 4'd2;
  localparam logic [3:0] EXE_SUB = 4'd3;
  localparam logic [3:0] EXE_AND = 4'd4;
  localparam logic [3:0] EXE_OR  = 4'd5;
  localparam logic [3:0] EXE_XOR = 4'd6;
  localparam logic [3:0] EXE_SLL = 4'd7;
  localparam logic [3:0] EXE_SRL = 4'd8;

  localparam logic [1:0] NO_BR  = 2'd0;
  localparam logic [1:0] BR_BEZ = 2'd1;
  localparam logic [1:0] BR_BNE = 2'd2;
  localparam logic [1:0] BR_JMP = 2'd3;

  typedef struct packed {
    logic       valid;
    logic [3:0] exe_cmd;
    logic [1:0] br_type;
    logic       mem_r_en;
    logic       mem_w_en;
    logic       wb_en;
  } id_ex_ctrl_t;

endpackage

// File: rtl/id_stage_pipe_regfile_bypass.sv
// Register file with r0 hardwired to zero and an optional WB write-through.
// Reads are combinational; writes land on the rising clock edge.
module regfile_bypass #(
  parameter int DATA_W    = 32,
  parameter int REG_AW    = 5,
  parameter int WB_BYPASS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] ra1,
  input  logic [REG_AW-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic              we,
  input  logic [REG_AW-1:0] wa,
  input  logic [DATA_W-1:0] wd
);

  localparam int  NREG = 1 << REG_AW;
  localparam bit  BYP  = (WB_BYPASS != 0);

  logic [DATA_W-1:0] mem [NREG];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        mem[i] <= '0;
      end
    end else if (we && (wa != '0)) begin
      mem[wa] <= wd;
    end
  end

  // r0 reads zero even though its storage is never written
  always_comb begin
    rd1 = '0;
    if (ra1 != '0) begin
      if (BYP && we && (wa == ra1)) rd1 = wd;
      else                          rd1 = mem[ra1];
    end
  end

  always_comb begin
    rd2 = '0;
    if (ra2 != '0) begin
      if (BYP && we && (wa == ra2)) rd2 = wd;
      else                          rd2 = mem[ra2];
    end
  end

endmodule

// File: rtl/id_stage_pipe.sv
// Decode stage: operand fetch, sign extend, load-use stall, flush,
// and the ID/EXE pipeline register feeding EXE.
module id_stage_pipe
  import id_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int REG_AW    = 5,
  parameter int WB_BYPASS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  input  logic [31:0]       instr,
  input  logic              ctrl_is_imm,
  input  logic [3:0]        ctrl_exe_cmd,
  input  logic [1:0]        ctrl_br_type,
  input  logic              ctrl_mem_r_en,
  input  logic              ctrl_mem_w_en,
  input  logic              ctrl_wb_en,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_dest,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              flush,
  output logic              stall,
  output logic              ex_valid,
  output logic [REG_AW-1:0] ex_dest,
  output logic [REG_AW-1:0] ex_src1,
  output logic [REG_AW-1:0] ex_src2,
  output logic [DATA_W-1:0] ex_val1,
  output logic [DATA_W-1:0] ex_val2,
  output logic [DATA_W-1:0] ex_reg2,
  output logic [3:0]        ex_exe_cmd,
  output logic [1:0]        ex_br_type,
  output logic              ex_mem_r_en,
  output logic              ex_mem_w_en,
  output logic              ex_wb_en
);

  logic [REG_AW-1:0] src1;
  logic [REG_AW-1:0] src2;
  logic [REG_AW-1:0] rd_f;
  logic [REG_AW-1:0] dest;
  logic [DATA_W-1:0] reg1;
  logic [DATA_W-1:0] reg2;
  logic [DATA_W-1:0] imm_ext;
  logic [DATA_W-1:0] val2;
  logic              uses_src2;
  logic              hazard;
  logic              bubble;

  id_ex_ctrl_t ctrl_d;
  id_ex_ctrl_t ctrl_q;

  logic [REG_AW-1:0] dest_q;
  logic [REG_AW-1:0] src1_q;
  logic [REG_AW-1:0] src2_q;
  logic [DATA_W-1:0] val1_q;
  logic [DATA_W-1:0] val2_q;
  logic [DATA_W-1:0] reg2_q;

  assign src1 = REG_AW'(instr[SRC1_HI:SRC1_LO]);
  assign src2 = REG_AW'(instr[SRC2_HI:SRC2_LO]);
  assign rd_f = REG_AW'(instr[RD_HI:RD_LO]);

  regfile_bypass #(
    .DATA_W    (DATA_W),
    .REG_AW    (REG_AW),
    .WB_BYPASS (WB_BYPASS)
  ) u_rf (
    .clk (clk),
    .rst (rst),
    .ra1 (src1),
    .ra2 (src2),
    .rd1 (reg1),
    .rd2 (reg2),
    .we  (wb_we),
    .wa  (wb_dest),
    .wd  (wb_data)
  );

  assign imm_ext = DATA_W'($signed(instr[IMM_W-1:0]));
  assign val2    = ctrl_is_imm ? imm_ext : reg2;
  assign dest    = ctrl_is_imm ? src2 : rd_f;

  assign uses_src2 = !ctrl_is_imm || ctrl_mem_w_en;

  assign hazard = instr_valid && ctrl_q.valid && ctrl_q.mem_r_en
               && (dest_q != '0)
               && ((dest_q == src1)
                   || (uses_src2 && (dest_q == src2)));

  assign stall  = hazard && !flush;
  assign bubble = flush || hazard;

  // an invalid slot still loads data, but must not act downstream
  always_comb begin
    ctrl_d          = '0;
    ctrl_d.exe_cmd  = ctrl_exe_cmd;
    if (instr_valid) begin
      ctrl_d.valid    = 1'b1;
      ctrl_d.br_type  = ctrl_br_type;
      ctrl_d.mem_r_en = ctrl_mem_r_en;
      ctrl_d.mem_w_en = ctrl_mem_w_en;
      ctrl_d.wb_en    = ctrl_wb_en;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q <= '0;
      dest_q <= '0;
      src1_q <= '0;
      src2_q <= '0;
      val1_q <= '0;
      val2_q <= '0;
      reg2_q <= '0;
    end else if (bubble) begin
      ctrl_q <= '0;
      dest_q <= '0;
      src1_q <= '0;
      src2_q <= '0;
      val1_q <= '0;
      val2_q <= '0;
      reg2_q <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      dest_q <= dest;
      src1_q <= src1;
      src2_q <= src2;
      val1_q <= reg1;
      val2_q <= val2;
      reg2_q <= reg2;
    end
  end

  assign ex_valid    = ctrl_q.valid;
  assign ex_exe_cmd  = ctrl_q.exe_cmd;
  assign ex_br_type  = ctrl_q.br_type;
  assign ex_mem_r_en = ctrl_q.mem_r_en;
  assign ex_mem_w_en = ctrl_q.mem_w_en;
  assign ex_wb_en    = ctrl_q.wb_en;
  assign ex_dest     = dest_q;
  assign ex_src1     = src1_q;
  assign ex_src2     = src2_q;
  assign ex_val1     = val1_q;
  assign ex_val2     = val2_q;
  assign ex_reg2     = reg2_q;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed plus random bench for id_stage_pipe against a behavioural model.
// A second instance with the WB write-through disabled shares all inputs.
module tb_id_stage_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic [31:0] instr;
  logic        ctrl_is_imm;
  logic [3:0]  ctrl_exe_cmd;
  logic [1:0]  ctrl_br_type;
  logic        ctrl_mem_r_en;
  logic        ctrl_mem_w_en;
  logic        ctrl_wb_en;
  logic        wb_we;
  logic [4:0]  wb_dest;
  logic [31:0] wb_data;
  logic        flush;

  logic        stall, ex_valid, ex_mem_r_en, ex_mem_w_en, ex_wb_en;
  logic [4:0]  ex_dest, ex_src1, ex_src2;
  logic [31:0] ex_val1, ex_val2, ex_reg2;
  logic [3:0]  ex_exe_cmd;
  logic [1:0]  ex_br_type;

  logic        n_stall, n_valid, n_mr, n_mw, n_wb;
  logic [4:0]  n_dest, n_src1, n_src2;
  logic [31:0] n_val1, n_val2, n_reg2;
  logic [3:0]  n_cmd;
  logic [1:0]  n_br;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_stage_pipe #(.DATA_W(32), .REG_AW(5), .WB_BYPASS(1)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr),
    .ctrl_is_imm(ctrl_is_imm), .ctrl_exe_cmd(ctrl_exe_cmd),
    .ctrl_br_type(ctrl_br_type), .ctrl_mem_r_en(ctrl_mem_r_en),
    .ctrl_mem_w_en(ctrl_mem_w_en), .ctrl_wb_en(ctrl_wb_en),
    .wb_we(wb_we), .wb_dest(wb_dest), .wb_data(wb_data), .flush(flush),
    .stall(stall), .ex_valid(ex_valid), .ex_dest(ex_dest),
    .ex_src1(ex_src1), .ex_src2(ex_src2), .ex_val1(ex_val1),
    .ex_val2(ex_val2), .ex_reg2(ex_reg2), .ex_exe_cmd(ex_exe_cmd),
    .ex_br_type(ex_br_type), .ex_mem_r_en(ex_mem_r_en),
    .ex_mem_w_en(ex_mem_w_en), .ex_wb_en(ex_wb_en)
  );

  id_stage_pipe #(.DATA_W(32), .REG_AW(5), .WB_BYPASS(0)) dut0 (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr),
    .ctrl_is_imm(ctrl_is_imm), .ctrl_exe_cmd(ctrl_exe_cmd),
    .ctrl_br_type(ctrl_br_type), .ctrl_mem_r_en(ctrl_mem_r_en),
    .ctrl_mem_w_en(ctrl_mem_w_en), .ctrl_wb_en(ctrl_wb_en),
    .wb_we(wb_we), .wb_dest(wb_dest), .wb_data(wb_data), .flush(flush),
    .stall(n_stall), .ex_valid(n_valid), .ex_dest(n_dest),
    .ex_src1(n_src1), .ex_src2(n_src2), .ex_val1(n_val1),
    .ex_val2(n_val2), .ex_reg2(n_reg2), .ex_exe_cmd(n_cmd),
    .ex_br_type(n_br), .ex_mem_r_en(n_mr),
    .ex_mem_w_en(n_mw), .ex_wb_en(n_wb)
  );

  // reference state: architectural registers and the expected ID/EXE slot
  logic [31:0] m_regs [32];
  logic        m_valid, m_mr, m_mw, m_wb;
  logic [4:0]  m_dest, m_src1, m_src2;
  logic [31:0] m_val1, m_val2, m_reg2, m_val1_nb;
  logic [3:0]  m_cmd;
  logic [1:0]  m_br;
  logic        last_stall;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    m_valid = 0; m_mr = 0; m_mw = 0; m_wb = 0;
    m_dest = 0; m_src1 = 0; m_src2 = 0;
    m_val1 = 0; m_val2 = 0; m_reg2 = 0; m_val1_nb = 0;
    m_cmd = 0; m_br = 0;
    last_stall = 0;
  endtask

  function automatic logic [31:0] rd_model(input logic [4:0] a,
                                           input bit byp);
    if (a == 0) return 32'h0;
    if (byp && wb_we && wb_dest == a) return wb_data;
    return m_regs[a];
  endfunction

  task automatic check_outputs();
    chk("ex_valid", {31'h0, ex_valid}, {31'h0, m_valid});
    chk("ex_dest", {27'h0, ex_dest}, {27'h0, m_dest});
    chk("ex_src1", {27'h0, ex_src1}, {27'h0, m_src1});
    chk("ex_src2", {27'h0, ex_src2}, {27'h0, m_src2});
    chk("ex_val1", ex_val1, m_val1);
    chk("ex_val2", ex_val2, m_val2);
    chk("ex_reg2", ex_reg2, m_reg2);
    chk("ex_cmd", {28'h0, ex_exe_cmd}, {28'h0, m_cmd});
    chk("ex_br", {30'h0, ex_br_type}, {30'h0, m_br});
    chk("ex_mr", {31'h0, ex_mem_r_en}, {31'h0, m_mr});
    chk("ex_mw", {31'h0, ex_mem_w_en}, {31'h0, m_mw});
    chk("ex_wb", {31'h0, ex_wb_en}, {31'h0, m_wb});
    chk("nb_val1", n_val1, m_val1_nb);
  endtask

  // one clock: check stall, predict the slot, clock, then check the slot
  task automatic cycle();
    logic [4:0]  s1, s2;
    logic        use2, haz;
    logic [31:0] imm_ext;
    #1;
    s1 = instr[25:21];
    s2 = instr[20:16];
    use2 = !ctrl_is_imm || ctrl_mem_w_en;
    haz = instr_valid && m_valid && m_mr && (m_dest != 0)
       && (m_dest == s1 || (use2 && m_dest == s2));
    last_stall = haz && !flush;
    chk("stall", {31'h0, stall}, {31'h0, last_stall});
    imm_ext = {{16{instr[15]}}, instr[15:0]};
    @(posedge clk);
    if (flush || haz) begin
      m_valid = 0; m_mr = 0; m_mw = 0; m_wb = 0; m_br = 0; m_cmd = 0;
      m_dest = 0; m_src1 = 0; m_src2 = 0;
      m_val1 = 0; m_val2 = 0; m_reg2 = 0; m_val1_nb = 0;
    end else begin
      m_valid = instr_valid;
      m_mr = instr_valid && ctrl_mem_r_en;
      m_mw = instr_valid && ctrl_mem_w_en;
      m_wb = instr_valid && ctrl_wb_en;
      m_br = instr_valid ? ctrl_br_type : 2'd0;
      m_cmd = ctrl_exe_cmd;
      m_dest = ctrl_is_imm ? s2 : instr[15:11];
      m_src1 = s1;
      m_src2 = s2;
      m_val1 = rd_model(s1, 1);
      m_val1_nb = rd_model(s1, 0);
      m_reg2 = rd_model(s2, 1);
      m_val2 = ctrl_is_imm ? imm_ext : m_reg2;
    end
    if (wb_we && wb_dest != 0) m_regs[wb_dest] = wb_data;
    #1;
    check_outputs();
  endtask

  task automatic set_instr(input logic v, input logic [4:0] s1,
                           input logic [4:0] s2, input logic [15:0] imm,
                           input logic is_imm, input logic mr,
                           input logic mw, input logic wbe);
    instr_valid = v;
    instr = {6'h23, s1, s2, imm};
    ctrl_is_imm = is_imm;
    ctrl_mem_r_en = mr;
    ctrl_mem_w_en = mw;
    ctrl_wb_en = wbe;
    ctrl_exe_cmd = 4'd2;
    ctrl_br_type = 2'd0;
  endtask

  task automatic set_wb(input logic we, input logic [4:0] d,
                        input logic [31:0] v);
    wb_we = we;
    wb_dest = d;
    wb_data = v;
  endtask

  initial begin
    rst = 1'b1;
    flush = 0;
    set_instr(0, 0, 0, 16'h0, 0, 0, 0, 0);
    set_wb(0, 0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    chk("rst_stall", {31'h0, stall}, 32'h0);
    rst = 1'b0;

    // WB write-through to the ID read port in the same cycle
    set_wb(1, 5'd3, 32'hDEADBEEF);
    set_instr(1, 5'd3, 5'd0, 16'h0800, 0, 0, 0, 1);
    cycle();
    chk("byp_on", ex_val1, 32'hDEADBEEF);
    chk("byp_off", n_val1, 32'h0);

    // writes to r0 are dropped
    set_wb(1, 5'd0, 32'h1234);
    set_instr(1, 5'd0, 5'd3, 16'h1000, 0, 0, 0, 1);
    cycle();
    set_wb(0, 0, 0);
    cycle();
    chk("r0_read", ex_val1, 32'h0);

    // immediate path selects src2 field as destination
    set_instr(1, 5'd3, 5'd9, 16'hFFFE, 1, 0, 0, 1);
    cycle();
    chk("imm_val2", ex_val2, 32'hFFFFFFFE);
    chk("imm_dest", {27'h0, ex_dest}, 32'd9);

    // load-use through src2 costs exactly one bubble
    set_instr(1, 5'd1, 5'd4, 16'h0010, 1, 1, 0, 1);
    cycle();
    set_instr(1, 5'd2, 5'd4, 16'h2800, 0, 0, 0, 1);
    #1;
    chk("lu_stall", {31'h0, stall}, 32'h1);
    cycle();
    chk("lu_bubble", {31'h0, ex_valid}, 32'h0);
    cycle();
    chk("lu_nostall", {31'h0, stall}, 32'h0);
    chk("lu_consumer", {31'h0, ex_valid}, 32'h1);

    // immediate consumer without a store does not read src2
    set_instr(1, 5'd1, 5'd4, 16'h0010, 1, 1, 0, 1);
    cycle();
    set_instr(1, 5'd2, 5'd4, 16'h0005, 1, 0, 0, 1);
    #1;
    chk("imm_nohaz", {31'h0, stall}, 32'h0);
    cycle();
    chk("imm_nohaz_v", {31'h0, ex_valid}, 32'h1);

    // flush wins over a simultaneous load-use hazard
    set_instr(1, 5'd1, 5'd4, 16'h0010, 1, 1, 0, 1);
    cycle();
    set_instr(1, 5'd4, 5'd0, 16'h2800, 0, 0, 0, 1);
    flush = 1;
    #1;
    chk("flush_stall", {31'h0, stall}, 32'h0);
    cycle();
    flush = 0;
    chk("flush_valid", {31'h0, ex_valid}, 32'h0);
    chk("flush_wb", {31'h0, ex_wb_en}, 32'h0);

    // reset while stalled clears the slot and the stall at once
    set_wb(1, 5'd5, 32'h55AA55AA);
    set_instr(1, 5'd1, 5'd4, 16'h0010, 1, 1, 0, 1);
    cycle();
    set_wb(0, 0, 0);
    set_instr(1, 5'd4, 5'd5, 16'h2800, 0, 0, 0, 1);
    #1;
    chk("pre_rst_stall", {31'h0, stall}, 32'h1);
    rst = 1'b1;
    #1;
    model_reset();
    chk("rst_mid_stall", {31'h0, stall}, 32'h0);
    check_outputs();
    #1;
    rst = 1'b0;
    set_instr(1, 5'd5, 5'd0, 16'h0800, 0, 0, 0, 1);
    cycle();
    chk("r5_after_rst", ex_val1, 32'h0);

    // random traffic on a small register window to provoke hazards
    for (int n = 0; n < 400; n++) begin
      if (!last_stall) begin
        instr_valid = ($urandom_range(0, 9) != 0);
        instr = $urandom;
        instr[25:21] = 5'($urandom_range(0, 7));
        instr[20:16] = 5'($urandom_range(0, 7));
        ctrl_is_imm = 1'($urandom);
        ctrl_exe_cmd = 4'($urandom);
        ctrl_br_type = 2'($urandom);
        ctrl_mem_r_en = ($urandom_range(0, 2) == 0);
        ctrl_mem_w_en = !ctrl_mem_r_en && ($urandom_range(0, 3) == 0);
        ctrl_wb_en = 1'($urandom);
      end
      set_wb(1'($urandom), 5'($urandom_range(0, 7)), $urandom);
      flush = ($urandom_range(0, 11) == 0);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
